// File: rtl/alu_spi_pkg.sv
// alu_spi_pkg: shared types and frame sizes for the ALU SPI link.
package alu_spi_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_t;

    localparam int unsigned CMD_BITS = 66;
    localparam int unsigned RES_BITS = 32;

    // Literals carry a prefix so they cannot collide with the master's
    // LEAD/GAP/RX_LEAD timing parameters.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SEND,
        ST_GAP,
        ST_RX_LEAD,
        ST_RECV,
        ST_DONE
    } master_state_t;

endpackage

// File: rtl/if_spi.sv
// IF_SPI: four-wire SPI link between the ALU master and the ALU slave.
interface IF_SPI;
    logic nss;
    logic mosi;
    logic sclk;
    logic miso;

    modport MASTER (output nss, output mosi, output sclk, input miso);
    modport SLAVE  (input nss, input mosi, input sclk, output miso);
endinterface

// File: rtl/alu_spi_master_bit_timer.sv
// spi_bit_timer: CLK_DIV bit-period divider for alu_spi_master.
// Macro ALU_SPI_MASTER_SCLK_EN enables the sclk phase output; without it
// sclk_phase is tied low.
module spi_bit_timer #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic bit_last,
    output logic sclk_phase
);
    localparam int unsigned CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Next count: cleared between phases, wraps at the end of each bit period.
    always_comb begin
        cnt_next = cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (run) begin
            cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign bit_last = run && (cnt == LAST);

`ifdef ALU_SPI_MASTER_SCLK_EN
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    // Phase of the cycle that starts at the next edge, so it can feed a flop.
    assign sclk_phase = (cnt_next >= HALF);
`else
    assign sclk_phase = 1'b0;
`endif

    // Divider count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
endmodule

// File: rtl/alu_spi_master.sv
// alu_spi_master: sends {opcode,opa,opb} to the ALU slave over IF_SPI, then
// clocks back the 32-bit result. Macro ALU_SPI_MASTER_SCLK_EN drives a real
// sclk during SEND/RECV; otherwise sclk stays low.
module alu_spi_master
    import alu_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned LEAD    = 2,
    parameter int unsigned GAP     = 4,
    parameter int unsigned RX_LEAD = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  opcode,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    IF_SPI.MASTER       spi
);
    if (CLK_DIV < 1 || LEAD < 1 || GAP < 1 || RX_LEAD < 1) begin : g_param_check
        $error("alu_spi_master: CLK_DIV, LEAD, GAP and RX_LEAD must all be >= 1");
    end

    localparam int unsigned WMAX = (LEAD > GAP) ? ((LEAD > RX_LEAD) ? LEAD : RX_LEAD)
                                                : ((GAP > RX_LEAD) ? GAP : RX_LEAD);
    localparam int unsigned WW = $clog2(WMAX + 1);
    localparam logic [WW-1:0] LEAD_LAST = WW'(LEAD - 1);
    localparam logic [WW-1:0] GAP_LAST  = WW'(GAP - 1);
    localparam logic [WW-1:0] RXL_LAST  = WW'(RX_LEAD - 1);
    localparam logic [6:0]    CMD_LAST  = 7'(CMD_BITS - 1);
    localparam logic [6:0]    RES_LAST  = 7'(RES_BITS - 1);

    master_state_t         state, state_n;
    logic [6:0]            bit_cnt, bit_cnt_n;
    logic [WW-1:0]         wait_cnt, wait_cnt_n;
    logic [CMD_BITS-1:0]   shreg, shreg_n;
    logic [RES_BITS-1:0]   rxreg, rxreg_n;
    logic [31:0]           result_n;
    logic                  nss_q, nss_n;
    logic                  mosi_q, mosi_n;
    logic                  sclk_q, sclk_n;
    logic                  busy_n, done_n;
    logic                  timer_run, bit_last, sclk_phase;

    assign timer_run = (state == ST_SEND) || (state == ST_RECV);

    spi_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (!timer_run),
        .run        (timer_run),
        .bit_last   (bit_last),
        .sclk_phase (sclk_phase)
    );

    assign spi.nss  = nss_q;
    assign spi.mosi = mosi_q;
    assign spi.sclk = sclk_q;

    // Next state plus next values of every registered output.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        wait_cnt_n = wait_cnt;
        shreg_n    = shreg;
        rxreg_n    = rxreg;
        result_n   = result;
        nss_n      = nss_q;
        mosi_n     = mosi_q;
        busy_n     = busy;
        done_n     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                nss_n  = 1'b1;
                mosi_n = 1'b0;
                busy_n = 1'b0;
                if (start) begin
                    state_n    = ST_LEAD;
                    wait_cnt_n = '0;
                    shreg_n    = {opcode, opa, opb};
                    nss_n      = 1'b0;
                    mosi_n     = opcode[1];
                    busy_n     = 1'b1;
                end
            end
            ST_LEAD: begin
                if (wait_cnt == LEAD_LAST) begin
                    state_n   = ST_SEND;
                    bit_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + WW'(1);
                end
            end
            ST_SEND: begin
                if (bit_last) begin
                    if (bit_cnt == CMD_LAST) begin
                        state_n    = ST_GAP;
                        wait_cnt_n = '0;
                        nss_n      = 1'b1;
                        mosi_n     = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + 7'd1;
                        shreg_n   = {shreg[CMD_BITS-2:0], 1'b0};
                        mosi_n    = shreg[CMD_BITS-2];
                    end
                end
            end
            ST_GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    state_n    = ST_RX_LEAD;
                    wait_cnt_n = '0;
                    nss_n      = 1'b0;
                end else begin
                    wait_cnt_n = wait_cnt + WW'(1);
                end
            end
            ST_RX_LEAD: begin
                if (wait_cnt == RXL_LAST) begin
                    state_n   = ST_RECV;
                    bit_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + WW'(1);
                end
            end
            ST_RECV: begin
                if (bit_last) begin
                    rxreg_n = {rxreg[RES_BITS-2:0], spi.miso};
                    if (bit_cnt == RES_LAST) begin
                        state_n = ST_DONE;
                        nss_n   = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 7'd1;
                    end
                end
            end
            ST_DONE: begin
                result_n = rxreg;
                done_n   = 1'b1;
                busy_n   = 1'b0;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        // sclk is only ever high in bit periods; phase is zero without the macro.
        sclk_n = ((state_n == ST_SEND) || (state_n == ST_RECV)) && sclk_phase;
    end

    // State, counters, shift registers and all outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            shreg    <= '0;
            rxreg    <= '0;
            result   <= '0;
            nss_q    <= 1'b1;
            mosi_q   <= 1'b0;
            sclk_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            wait_cnt <= wait_cnt_n;
            shreg    <= shreg_n;
            rxreg    <= rxreg_n;
            result   <= result_n;
            nss_q    <= nss_n;
            mosi_q   <= mosi_n;
            sclk_q   <= sclk_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_alu_spi_master.sv
// tb_alu_spi_master: directed and random transactions on two masters
// (CLK_DIV=1 and CLK_DIV=3) against a behavioural ALU slave.
module tb_alu_spi_master;
    import alu_spi_pkg::*;

    localparam int unsigned LEAD_C = 2, GAP_C = 4, RX_LEAD_C = 2;
    localparam int unsigned DIV0 = 1, DIV1 = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [1:0]       start_w;
    logic [1:0][1:0]  op_w;
    logic [1:0][31:0] opa_w, opb_w, res_w;
    logic [1:0]       busy_w, done_w, nss_w, mosi_w, sclk_w;
    logic [1:0]       miso_w = '0;

    IF_SPI spi0();
    IF_SPI spi1();
    assign nss_w[0]  = spi0.nss;
    assign mosi_w[0] = spi0.mosi;
    assign sclk_w[0] = spi0.sclk;
    assign spi0.miso = miso_w[0];
    assign nss_w[1]  = spi1.nss;
    assign mosi_w[1] = spi1.mosi;
    assign sclk_w[1] = spi1.sclk;
    assign spi1.miso = miso_w[1];

    alu_spi_master #(.CLK_DIV(DIV0), .LEAD(LEAD_C), .GAP(GAP_C), .RX_LEAD(RX_LEAD_C)) dut_div1 (
        .clock(clock), .reset(reset), .start(start_w[0]), .opcode(op_w[0]),
        .opa(opa_w[0]), .opb(opb_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .result(res_w[0]), .spi(spi0)
    );
    alu_spi_master #(.CLK_DIV(DIV1), .LEAD(LEAD_C), .GAP(GAP_C), .RX_LEAD(RX_LEAD_C)) dut_div3 (
        .clock(clock), .reset(reset), .start(start_w[1]), .opcode(op_w[1]),
        .opa(opa_w[1]), .opb(opb_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .result(res_w[1]), .spi(spi1)
    );

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int unsigned div_of(input int d);
        return (d == 0) ? DIV0 : DIV1;
    endfunction

    // Slave / monitor state, one entry per DUT.
    int unsigned lowcnt[2], cmd_len[2], rsp_len[2];
    int unsigned rises[2], cmd_rises[2], rsp_rises[2], sclk_bad[2];
    int unsigned done_cnt[2], done_cyc[2];
    bit          phase[2], sclk_prev[2], done_prev[2];
    logic        busy_at_done[2], nss_after_done[2];
    logic [65:0] frame_sh[2], last_frame[2];
    logic [31:0] resp[2];

    // ALU slave model: decode nss windows, capture the command, return the result.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            int unsigned dv, ld, k;
            logic exp_sclk;
            dv = div_of(d);
            if (done_prev[d]) nss_after_done[d] = nss_w[d];
            done_prev[d] = done_w[d];
            if (reset) begin
                lowcnt[d] = 0; phase[d] = 0; miso_w[d] = 1'b0;
                sclk_prev[d] = 0; rises[d] = 0;
            end else begin
                if (done_w[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                    busy_at_done[d] = busy_w[d];
                end
                exp_sclk = 1'b0;
                if (nss_w[d] == 1'b0) begin
                    lowcnt[d]++;
                    ld = phase[d] ? RX_LEAD_C : LEAD_C;
                    if (lowcnt[d] > ld) begin
                        k = lowcnt[d] - 1 - ld;
`ifdef ALU_SPI_MASTER_SCLK_EN
                        exp_sclk = ((k % dv) >= (dv / 2));
`endif
                        if (!phase[d] && (k % dv == dv - 1))
                            frame_sh[d] = {frame_sh[d][64:0], mosi_w[d]};
                        if (phase[d] && (k / dv < 32))
                            miso_w[d] = resp[d][31 - k / dv];
                    end
                    if (sclk_w[d] && !sclk_prev[d]) rises[d]++;
                end else if (lowcnt[d] != 0) begin
                    if (!phase[d]) begin
                        cmd_len[d]    = lowcnt[d];
                        cmd_rises[d]  = rises[d];
                        last_frame[d] = frame_sh[d];
                        resp[d] = alu_ref(frame_sh[d][65:64], frame_sh[d][63:32], frame_sh[d][31:0]);
                    end else begin
                        rsp_len[d]   = lowcnt[d];
                        rsp_rises[d] = rises[d];
                    end
                    phase[d]  = !phase[d];
                    lowcnt[d] = 0;
                    rises[d]  = 0;
                    miso_w[d] = 1'b0;
                end
                if (sclk_w[d] !== exp_sclk) sclk_bad[d]++;
                sclk_prev[d] = sclk_w[d];
            end
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic launch(input int d, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int unsigned t0);
        op_w[d] = op; opa_w[d] = a; opb_w[d] = b; start_w[d] = 1'b1;
        step();
        t0 = cyc;
        start_w[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int unsigned n0, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (done_cnt[d] != n0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic check_txn(input int d, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int unsigned t0, input string tag);
        int unsigned dv;
        dv = div_of(d);
        check({tag, "/result"},  res_w[d], alu_ref(op, a, b));
        check({tag, "/latency"}, done_cyc[d] - t0, 1 + LEAD_C + 66 * dv + GAP_C + RX_LEAD_C + 32 * dv);
        check({tag, "/busy_at_done"}, busy_at_done[d], 1'b0);
        check({tag, "/frame"},   last_frame[d], {op, a, b});
        check({tag, "/cmd_window"}, cmd_len[d], LEAD_C + 66 * dv);
        check({tag, "/rsp_window"}, rsp_len[d], RX_LEAD_C + 32 * dv);
    endtask

    task automatic do_txn(input int d, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int unsigned t0, n0;
        bit ok;
        n0 = done_cnt[d];
        launch(d, op, a, b, t0);
        wait_done(d, n0, ok);
        check({tag, "/done_seen"}, ok, 1'b1);
        check_txn(d, op, a, b, t0, tag);
    endtask

    initial begin
        int unsigned t0, t1, n0;
        bit ok;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start_w = '0; op_w = '0; opa_w = '0; opb_w = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        for (int d = 0; d < 2; d++) begin
            check("reset/nss",    nss_w[d],  1'b1);
            check("reset/mosi",   mosi_w[d], 1'b0);
            check("reset/sclk",   sclk_w[d], 1'b0);
            check("reset/busy",   busy_w[d], 1'b0);
            check("reset/done",   done_w[d], 1'b0);
            check("reset/result", res_w[d],  32'h0);
        end

        // Reset during SEND bit 30 aborts the frame without a done.
        n0 = done_cnt[0];
        launch(0, ADD, 32'h1234_5678, 32'h0000_1111, t0);
        check("abort/busy_before", busy_w[0], 1'b1);
        while (cyc < t0 + 32) step();
        reset = 1'b1;
        step();
        check("abort/nss",    nss_w[0],  1'b1);
        check("abort/busy",   busy_w[0], 1'b0);
        check("abort/result", res_w[0],  32'h0);
        check("abort/done",   done_w[0], 1'b0);
        reset = 1'b0;
        repeat (150) step();
        check("abort/no_done", done_cnt[0], n0);
        check("abort/nss_idle", nss_w[0], 1'b1);

        do_txn(0, ADD, 32'd5, 32'd3, "add");
        check("add/result8", res_w[0], 32'h0000_0008);

        do_txn(0, SUB, 32'hDEAD_BEEF, 32'h0, "sub");
        check("sub/first6", last_frame[0][65:60], 6'b011101);

        // A start pulse while busy must not disturb the frame in flight.
        n0 = done_cnt[0];
        launch(0, AND, 32'hF0F0_1234, 32'h0FF0_FFFF, t0);
        while (cyc < t0 + 20) step();
        op_w[0] = OR; opa_w[0] = 32'h1111_1111; opb_w[0] = 32'h2222_2222; start_w[0] = 1'b1;
        step();
        start_w[0] = 1'b0;
        wait_done(0, n0, ok);
        check("ignore/done_seen", ok, 1'b1);
        check_txn(0, AND, 32'hF0F0_1234, 32'h0FF0_FFFF, t0, "ignore");
        repeat (200) step();
        check("ignore/single_done", done_cnt[0], n0 + 1);

        // start held high through done: the second request follows at once.
        n0 = done_cnt[0];
        op_w[0] = SUB; opa_w[0] = 32'd100; opb_w[0] = 32'd1; start_w[0] = 1'b1;
        step();
        t0 = cyc;
        op_w[0] = OR; opa_w[0] = 32'h00FF_0000; opb_w[0] = 32'h0000_00FF;
        wait_done(0, n0, ok);
        check("b2b1/done_seen", ok, 1'b1);
        check_txn(0, SUB, 32'd100, 32'd1, t0, "b2b1");
        step();
        check("b2b/nss_after_done", nss_after_done[0], 1'b0);
        start_w[0] = 1'b0;
        t1 = done_cyc[0] + 1;
        wait_done(0, n0 + 1, ok);
        check("b2b2/done_seen", ok, 1'b1);
        check_txn(0, OR, 32'h00FF_0000, 32'h0000_00FF, t1, "b2b2");

        // CLK_DIV=3 master.
        do_txn(1, OR, 32'hA5A5_0000, 32'h0000_A5A5, "div3");
        check("div3/resultA5", res_w[1], 32'hA5A5_A5A5);
`ifdef ALU_SPI_MASTER_SCLK_EN
        check("div3/cmd_pulses", cmd_rises[1], 66);
        check("div3/rsp_pulses", rsp_rises[1], 32);
`else
        check("div3/cmd_pulses", cmd_rises[1], 0);
        check("div3/rsp_pulses", rsp_rises[1], 0);
`endif

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            do_txn((i < 4) ? 0 : 1, rop, ra, rb, "random");
        end

        check("sclk_shape/div1", sclk_bad[0], 0);
        check("sclk_shape/div3", sclk_bad[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
